// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Requester and memory bus bundle for mem_arbiter.
//   Requester side : req0/req1, we0/we1, lock0/lock1, addr0/addr1,
//                    wdata0/wdata1 (to arbiter); gnt0/gnt1, rvalid0/rvalid1,
//                    rdata0/rdata1 (from arbiter)
//   Memory side    : mem_en, mem_we, mem_addr, mem_wdata (from arbiter);
//                    mem_rdata (to arbiter, one cycle after a read strobe)
//   Status         : busy (from arbiter)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int WORD_LENGTH_32 = 32,
   parameter int ADDR_LENGTH    = 8
);
   logic                      req0,   req1;
   logic                      we0,    we1;
   logic                      lock0,  lock1;
   logic [ADDR_LENGTH-1:0]    addr0,  addr1;
   logic [WORD_LENGTH_32-1:0] wdata0, wdata1;
   logic                      gnt0,   gnt1;
   logic                      rvalid0, rvalid1;
   logic [WORD_LENGTH_32-1:0] rdata0, rdata1;
   logic                      mem_en, mem_we;
   logic [ADDR_LENGTH-1:0]    mem_addr;
   logic [WORD_LENGTH_32-1:0] mem_wdata;
   logic [WORD_LENGTH_32-1:0] mem_rdata;
   logic                      busy;

   modport slave (
      input  req0, req1, we0, we1, lock0, lock1,
      input  addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output req0, req1, we0, we1, lock0, lock1,
      output addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter in front of a single-port synchronous memory.
// One transaction in flight: IDLE (arbitrate) -> ACCESS (strobe memory)
// -> RESP (reads only, deliver mem_rdata). Ties go to the requester that
// was not granted last; a requester asserting lock keeps ownership for up
// to LOCK_MAX consecutive grants.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high reset
//   bus   - mem_arbiter_if.slave (requester handshakes + memory bus + busy)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int WORD_LENGTH_32 = 32,
   parameter int ADDR_LENGTH    = 8,
   parameter int LOCK_MAX       = 4
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   localparam int               CNT_W    = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_CAP = CNT_W'(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                    r_state;
   logic                      r_owner;       // requester of the transaction in flight
   logic                      r_last_grant;
   logic                      r_we;
   logic                      r_lock;
   logic [CNT_W-1:0]          r_lock_count;
   logic [WORD_LENGTH_32-1:0] r_rdata0;
   logic [WORD_LENGTH_32-1:0] r_rdata1;

   logic                      w_any_req;
   logic                      w_owner_req;
   logic                      w_lock_hold;
   logic                      w_winner;
   logic                      w_win_we;
   logic                      w_win_lock;
   logic [ADDR_LENGTH-1:0]    w_win_addr;
   logic [WORD_LENGTH_32-1:0] w_win_wdata;

   // Arbitration, evaluated every cycle but only acted on in IDLE.
   // NOTE: every signal gets a value on every path through this block, so no
   // latch is inferred.
   always_comb begin
      w_any_req   = bus.req0 | bus.req1;
      w_owner_req = r_owner ? bus.req1 : bus.req0;
      // A locked sequence continues only while the owner is still asking and
      // has not yet used up its LOCK_MAX grants.
      w_lock_hold = r_lock && (r_lock_count < LOCK_CAP) && w_owner_req;
      if (w_lock_hold) begin
         w_winner = r_owner;
      end else if (bus.req0 && bus.req1) begin
         w_winner = ~r_last_grant;
      end else begin
         w_winner = bus.req1;
      end
      w_win_we    = w_winner ? bus.we1    : bus.we0;
      w_win_lock  = w_winner ? bus.lock1  : bus.lock0;
      w_win_addr  = w_winner ? bus.addr1  : bus.addr0;
      w_win_wdata = w_winner ? bus.wdata1 : bus.wdata0;
   end

   // Single FSM process with registered outputs. mem_addr/mem_wdata double as
   // the latched address/data of the transaction in flight.
   // NOTE: state is assigned with non-blocking (<=) so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_owner       <= 1'b0;
         r_last_grant  <= 1'b1;           // requester 0 wins the first tie
         r_we          <= 1'b0;
         r_lock        <= 1'b0;
         r_lock_count  <= '0;
         r_rdata0      <= '0;
         r_rdata1      <= '0;
         bus.gnt0      <= 1'b0;
         bus.gnt1      <= 1'b0;
         bus.rvalid0   <= 1'b0;
         bus.rvalid1   <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.busy      <= 1'b0;
      end else begin
         // One-cycle pulses fall unless re-armed below.
         bus.gnt0    <= 1'b0;
         bus.gnt1    <= 1'b0;
         bus.rvalid0 <= 1'b0;
         bus.rvalid1 <= 1'b0;
         bus.mem_en  <= 1'b0;
         bus.mem_we  <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_state       <= ACCESS;
                  bus.busy      <= 1'b1;
                  r_owner       <= w_winner;
                  r_we          <= w_win_we;
                  r_lock        <= w_win_lock;
                  bus.mem_addr  <= w_win_addr;
                  bus.mem_wdata <= w_win_wdata;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= w_win_we;
                  bus.gnt0      <= ~w_winner;
                  bus.gnt1      <= w_winner;
                  // A continuing locked sequence leaves the fairness pointer
                  // alone, so the other requester wins once the lock ends.
                  if (!w_lock_hold) begin
                     r_last_grant <= w_winner;
                  end
                  if (!w_win_lock) begin
                     r_lock_count <= '0;
                  end else if (w_lock_hold) begin
                     r_lock_count <= r_lock_count + CNT_ONE;
                  end else begin
                     r_lock_count <= CNT_ONE;
                  end
               end else begin
                  // Owner dropped its request: the locked sequence is over.
                  r_lock_count <= '0;
               end
            end

            ACCESS: begin
               if (r_we) begin
                  r_state  <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  r_state     <= RESP;
                  bus.rvalid0 <= ~r_owner;
                  bus.rvalid1 <= r_owner;
               end
            end

            RESP: begin
               r_state  <= IDLE;
               bus.busy <= 1'b0;
               if (r_owner) begin
                  r_rdata1 <= bus.mem_rdata;
               end else begin
                  r_rdata0 <= bus.mem_rdata;
               end
            end

            default: begin
               r_state  <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

   // The memory returns data during RESP, after the edge that entered RESP,
   // so the owner's port passes mem_rdata straight through in that cycle and
   // shows the captured copy at all other times.
   assign bus.rdata0 = (r_state == RESP && !r_owner) ? bus.mem_rdata : r_rdata0;
   assign bus.rdata1 = (r_state == RESP &&  r_owner) ? bus.mem_rdata : r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter with a small synchronous
// memory model (registered read, one-cycle latency) and a backdoor preload.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic clk;
   logic reset;

   int n_total = 0;
   int n_bad   = 0;

   mem_arbiter_if #(.WORD_LENGTH_32(32), .ADDR_LENGTH(8)) bus ();

   mem_arbiter #(
      .WORD_LENGTH_32 (32),
      .ADDR_LENGTH    (8),
      .LOCK_MAX       (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model
   logic [31:0] mem [256];
   logic        bd_we;
   logic [7:0]  bd_addr;
   logic [31:0] bd_data;

   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (bus.mem_en && bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
      if (bus.mem_en && !bus.mem_we) begin
         bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy}
   function automatic logic [6:0] flags();
      return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
              bus.mem_en, bus.mem_we, bus.busy};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req0 = 1'b0;  bus.req1 = 1'b0;
      bus.we0  = 1'b0;  bus.we1  = 1'b0;
      bus.lock0 = 1'b0; bus.lock1 = 1'b0;
      bus.addr0 = '0;   bus.addr1 = '0;
      bus.wdata0 = '0;  bus.wdata1 = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      reset = 1'b0;
   endtask

   // One-hot grant / rvalid watch on every falling edge.
   always @(negedge clk) begin
      check("onehot", {30'b0, bus.gnt0 & bus.gnt1, bus.rvalid0 & bus.rvalid1}, 32'h0);
   end

   logic [1:0] want_g;

   initial begin
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      check("rst_flags",     {25'b0, flags()}, 32'h0);
      check("rst_rdata0",    bus.rdata0,       32'h0);
      check("rst_rdata1",    bus.rdata1,       32'h0);
      check("rst_mem_addr",  {24'b0, bus.mem_addr}, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata,    32'h0);
      reset = 1'b0;
      step();
      check("post_rst_flags", {25'b0, flags()}, 32'h0);

      // Preload mem[0x10]
      bd_we = 1'b1; bd_addr = 8'h10; bd_data = 32'hDEADBEEF;
      step();
      bd_we = 1'b0;

      // Basic read by requester 0
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
      step();                                            // c1 ACCESS
      check("rd_c1_flags", {25'b0, flags()}, 32'h45);
      check("rd_c1_addr",  {24'b0, bus.mem_addr}, 32'h10);
      bus.req0 = 1'b0;
      step();                                            // c2 RESP
      check("rd_c2_flags",  {25'b0, flags()}, 32'h11);
      check("rd_c2_rdata0", bus.rdata0, 32'hDEADBEEF);
      check("rd_c2_rdata1", bus.rdata1, 32'h0);
      step();                                            // c3 IDLE
      check("rd_c3_flags",  {25'b0, flags()}, 32'h0);
      check("rd_c3_hold0",  bus.rdata0, 32'hDEADBEEF);

      // Write by requester 1, read back by requester 0
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 32'h12345678;
      step();
      check("wr_flags", {25'b0, flags()}, 32'h27);
      check("wr_addr",  {24'b0, bus.mem_addr}, 32'h20);
      check("wr_wdata", bus.mem_wdata, 32'h12345678);
      bus.req1 = 1'b0; bus.we1 = 1'b0;
      step();
      check("wr_done_flags", {25'b0, flags()}, 32'h0);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h20;
      step();
      check("rb_flags", {25'b0, flags()}, 32'h45);
      bus.req0 = 1'b0;
      step();
      check("rb_rdata0", bus.rdata0, 32'h12345678);
      check("rb_rdata1", bus.rdata1, 32'h0);
      step();

      // Fairness: both reading continuously, no lock
      do_reset();
      bus.req0 = 1'b1; bus.addr0 = 8'h10;
      bus.req1 = 1'b1; bus.addr1 = 8'h20;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         step();
         if ((cyc - 1) % 3 == 0) want_g = (((cyc - 1) / 3) % 2 == 0) ? 2'b10 : 2'b01;
         else                    want_g = 2'b00;
         check("fair_gnt", {30'b0, bus.gnt0, bus.gnt1}, {30'b0, want_g});
      end
      clear_inputs();
      step();
      check("fair_idle", {25'b0, flags()}, 32'h0);

      // Lock cap: requester 0 locks, requester 1 keeps asking
      do_reset();
      bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 8'h10;
      bus.req1 = 1'b1; bus.addr1 = 8'h20;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         step();
         if ((cyc - 1) % 3 == 0) want_g = (((cyc - 1) / 3) % 5 == 4) ? 2'b01 : 2'b10;
         else                    want_g = 2'b00;
         check("lock_gnt", {30'b0, bus.gnt0, bus.gnt1}, {30'b0, want_g});
      end
      clear_inputs();
      step();

      // Reset during RESP of a requester-1 read
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
      step();
      check("rr_gnt1", {25'b0, flags()}, 32'h25);
      bus.req1 = 1'b0;
      step();
      check("rr_resp_flags", {25'b0, flags()}, 32'h09);
      check("rr_resp_rdata1", bus.rdata1, 32'h12345678);
      reset = 1'b1;
      bus.req0 = 1'b1; bus.addr0 = 8'h10;
      bus.req1 = 1'b1; bus.addr1 = 8'h20;
      step();
      check("rr_abort_flags", {25'b0, flags()}, 32'h0);
      check("rr_abort_rdata1", bus.rdata1, 32'h0);
      reset = 1'b0;
      step();
      check("rr_first_gnt0", {25'b0, flags()}, 32'h45);
      clear_inputs();
      step();
      check("rr_rdata0", bus.rdata0, 32'hDEADBEEF);
      step();

      // Late arrival of requester 1 during requester-0 ACCESS
      bus.req0 = 1'b1; bus.addr0 = 8'h10;
      step();                                            // c1 ACCESS
      check("late_c1", {30'b0, bus.gnt0, bus.gnt1}, 32'h2);
      bus.req0 = 1'b0;
      bus.req1 = 1'b1; bus.addr1 = 8'h20;
      step();                                            // c2 RESP
      check("late_c2", {30'b0, bus.gnt0, bus.gnt1}, 32'h0);
      step();                                            // c3 IDLE
      check("late_c3", {25'b0, flags()}, 32'h0);
      step();                                            // c4 ACCESS for req1
      check("late_c4", {25'b0, flags()}, 32'h25);
      bus.req1 = 1'b0;
      step();                                            // c5 RESP
      check("late_c5_flags",  {25'b0, flags()}, 32'h09);
      check("late_c5_rdata1", bus.rdata1, 32'h12345678);
      check("late_c5_rdata0", bus.rdata0, 32'hDEADBEEF);
      step();
      check("late_end", {25'b0, flags()}, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
